audio_lr_scheduler: RTL

// - Sequences two mono sample producers (left, right) into the single 28-bit write stream of the audio-out FIFO bridge.
// - Enforces strict L-then-R frame ordering and tags every word with its channel and a 3-bit frame sequence number.
// - Recovers from a missing right sample by timeout; the dropped frame is counted as a slip.
// - Raises a frame-count interrupt for the driver.
// - Sits between the audio sample sources and the bridge's source_valid/source_data/source_ready port.
//

---
 rtl/audio_lr_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/audio_lr_scheduler.sv
// rtl/audio_lr_scheduler.sv - left/right sample sequencer into the audio-out FIFO bridge
//
// Purpose:
//   Accepts one left then one right mono sample per frame and forwards them as
//   tagged words {ch, seq[2:0], sample} through a single registered output
//   stage. A right sample that does not arrive within TIMEOUT cycles of
//   waiting drops the frame as a slip. Completed frames are counted and raise a
//   level interrupt every IRQ_FRAMES frames.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   l_valid/l_data    left sample stream in;  l_ready out
//   r_valid/r_data    right sample stream in; r_ready out
//   sink_valid/data   tagged output word to the bridge; sink_ready[0] accepts it
//   irq_ack           one-cycle pulse clearing irq
//   irq               level interrupt, frame threshold reached
//   frame_count       completed frames (wrapping)
//   slip_count        timed-out frames (saturating)

module audio_lr_scheduler #(
    parameter int SAMPLE_W   = 24,
    parameter int DATA_SIZE  = 28,    // must equal SAMPLE_W + 4
    parameter int IRQ_FRAMES = 256,   // 1..65535
    parameter int TIMEOUT    = 1023   // >= 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l_valid,
    input  logic [SAMPLE_W-1:0]  l_data,
    output logic                 l_ready,
    input  logic                 r_valid,
    input  logic [SAMPLE_W-1:0]  r_data,
    output logic                 r_ready,
    output logic                 sink_valid,
    output logic [DATA_SIZE-1:0] sink_data,
    input  logic [1:0]           sink_ready,
    input  logic                 irq_ack,
    output logic                 irq,
    output logic [15:0]          frame_count,
    output logic [7:0]           slip_count
);

    // Timer only ever holds 0..TIMEOUT-1.
    localparam int                 TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [15:0]        IRQ_LAST   = 16'(IRQ_FRAMES - 1);

    typedef enum logic {
        S_L = 1'b0,
        S_R = 1'b1
    } state_t;

    state_t             state;
    logic [2:0]         seq;
    logic [TIMER_W-1:0] timer;
    logic [15:0]        irq_cnt;

    logic out_free;
    logic l_acc;
    logic r_acc;
    logic timeout_hit;
    logic irq_hit;
    logic sink_ready_unused;

    // Upper bridge ready bit carries no meaning for this block.
    assign sink_ready_unused = sink_ready[1];

    // The output stage can take a new word when empty or draining this cycle.
    assign out_free = !sink_valid || sink_ready[0];
    assign l_ready  = (state == S_L) && out_free;
    assign r_ready  = (state == S_R) && out_free;
    assign l_acc    = l_valid && l_ready;
    assign r_acc    = r_valid && r_ready;

    // The timer keeps running under bridge back-pressure, so a long stall
    // also slips the frame.
    assign timeout_hit = (state == S_R) && !r_acc && (timer == TIMER_LAST);
    assign irq_hit     = r_acc && (irq_cnt == IRQ_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_L;
            seq         <= 3'd0;
            timer       <= '0;
            irq_cnt     <= 16'd0;
            sink_valid  <= 1'b0;
            sink_data   <= '0;
            irq         <= 1'b0;
            frame_count <= 16'd0;
            slip_count  <= 8'd0;
        end else begin
            // Output register: load on accept, otherwise hold until taken.
            if (l_acc) begin
                sink_valid <= 1'b1;
                sink_data  <= {1'b0, seq, l_data};
            end else if (r_acc) begin
                sink_valid <= 1'b1;
                sink_data  <= {1'b1, seq, r_data};
            end else if (sink_ready[0]) begin
                sink_valid <= 1'b0;
            end

            case (state)
                S_L: begin
                    if (l_acc) begin
                        timer <= '0;
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (r_acc) begin
                        seq         <= seq + 3'd1;
                        frame_count <= frame_count + 16'd1;
                        state       <= S_L;
                    end else if (timeout_hit) begin
                        // Left word already left the block; only the frame is lost.
                        if (slip_count != 8'hFF) begin
                            slip_count <= slip_count + 8'd1;
                        end
                        seq   <= seq + 3'd1;
                        timer <= '0;
                        state <= S_L;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_L;
            endcase

            if (irq_hit) begin
                irq_cnt <= 16'd0;
            end else if (r_acc) begin
                irq_cnt <= irq_cnt + 16'd1;
            end

            // A threshold in the same cycle as an ack wins, so no event is lost.
            if (irq_hit) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule
